// File: rtl/ysyx_22040759_exec_seq.sv
// Multi-cycle execution sequencer: steps one instruction through fetch, decode,
// execute, optional load/store and writeback, trapping on illegal ops or memory timeouts.
//
// state  | meaning
// IDLE   | waiting for start_i
// FETCH  | instruction request outstanding
// DECODE | checking decoder flags, capturing next-PC source
// EXEC   | single ALU cycle
// MEM    | load/store request outstanding
// WB     | retire: register file and PC update
// TRAP   | sticky error, left only through reset
module ysyx_22040759_exec_seq #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             halt_i,
    output logic             ifu_req_o,
    input  logic             ifu_rvalid_i,
    output logic             ir_we_o,
    input  logic             reg_wen_i,
    input  logic             mem_wen_i,
    input  logic             mem_ren_i,
    input  logic             pc_sel_i,
    input  logic             inst_illegal_i,
    output logic             lsu_req_o,
    output logic             lsu_we_o,
    input  logic             lsu_ack_i,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic             busy_o,
    output logic             trap_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] inst_cnt_o
);

    localparam int TW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    // Counter holds the number of wait cycles already spent, so the last allowed one is TIMEOUT-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_src_q, pc_src_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        cnt_d     = cnt_q;
        pc_src_d  = pc_src_q;
        ifu_req_o = 1'b0;
        ir_we_o   = 1'b0;
        lsu_req_o = 1'b0;
        lsu_we_o  = 1'b0;
        rf_we_o   = 1'b0;
        pc_we_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                ifu_req_o = 1'b1;
                if (ifu_rvalid_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (inst_illegal_i || (mem_wen_i && mem_ren_i)) begin
                    state_d = S_TRAP;
                end else begin
                    pc_src_d = pc_sel_i;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (mem_wen_i || mem_ren_i) ? S_MEM : S_WB;
            end
            S_MEM: begin
                lsu_req_o = 1'b1;
                lsu_we_o  = mem_wen_i;
                if (lsu_ack_i) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                pc_we_o = 1'b1;
                rf_we_o = reg_wen_i;
                cnt_d   = cnt_q + 1'b1;
                state_d = halt_i ? S_IDLE : S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            cnt_q    <= '0;
            pc_src_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            pc_src_q <= pc_src_d;
        end
    end

    assign pc_src_o   = pc_src_q;
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign trap_o     = (state_q == S_TRAP);
    assign state_o    = state_q;
    assign inst_cnt_o = cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_exec_seq.sv
// Bench for the execution sequencer: an instruction-level model expands each
// randomized instruction into its expected per-cycle outputs, checked every cycle.
module tb_ysyx_22040759_exec_seq;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0, halt_i = 1'b0, ifu_rvalid_i = 1'b0, lsu_ack_i = 1'b0;
    logic          reg_wen_i = 1'b0, mem_wen_i = 1'b0, mem_ren_i = 1'b0;
    logic          pc_sel_i = 1'b0, inst_illegal_i = 1'b0;
    logic          ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o;
    logic          pc_src_o, busy_o, trap_o;
    logic [2:0]    state_o;
    logic [CW-1:0] inst_cnt_o;

    always #5 clk = ~clk;

    ysyx_22040759_exec_seq #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i),
        .ifu_req_o(ifu_req_o), .ifu_rvalid_i(ifu_rvalid_i), .ir_we_o(ir_we_o),
        .reg_wen_i(reg_wen_i), .mem_wen_i(mem_wen_i), .mem_ren_i(mem_ren_i),
        .pc_sel_i(pc_sel_i), .inst_illegal_i(inst_illegal_i),
        .lsu_req_o(lsu_req_o), .lsu_we_o(lsu_we_o), .lsu_ack_i(lsu_ack_i),
        .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
        .busy_o(busy_o), .trap_o(trap_o), .state_o(state_o), .inst_cnt_o(inst_cnt_o)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic          ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, pc_src, busy, trap;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t       act;
    obs_t       expq[$];
    logic [2:0] st_log[$];
    logic [2:0] exp_log[$];
    int         errors = 0;
    int         checks = 0;
    int         model_cnt = 0;
    logic       model_pc_src = 1'b0;
    int         rf_cnt = 0, pc_cnt = 0, lsu_hi = 0, lsu_we_hi = 0, mem_cyc = 0;

    assign act = {state_o, ifu_req_o, ir_we_o, lsu_req_o, lsu_we_o, rf_we_o, pc_we_o,
                  pc_src_o, busy_o, trap_o, inst_cnt_o};

    always @(negedge clk) begin
        obs_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            st_log.push_back(state_o);
            if (rf_we_o) rf_cnt++;
            if (pc_we_o) pc_cnt++;
            if (lsu_req_o) lsu_hi++;
            if (lsu_we_o) lsu_we_hi++;
            if (state_o == 3'd4) mem_cyc++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t: actual st=%0d strobes=%b cnt=%0d, expected st=%0d strobes=%b cnt=%0d",
                         $time, act.st, act[12:4], act.cnt, e.st, e[12:4], e.cnt);
            end
        end
    end

    // Expected outputs for one cycle in a given sequencer phase.
    function automatic obs_t mk(input logic [2:0] st, input logic ir_we, input logic lsu_we,
                                input logic rf_we);
        obs_t o;
        o.st      = st;
        o.ifu_req = (st == 3'd1);
        o.ir_we   = ir_we;
        o.lsu_req = (st == 3'd4);
        o.lsu_we  = lsu_we;
        o.rf_we   = rf_we;
        o.pc_we   = (st == 3'd5);
        o.pc_src  = model_pc_src;
        o.busy    = (st != 3'd0) && (st != 3'd6);
        o.trap    = (st == 3'd6);
        o.cnt     = CW'(model_cnt % (1 << CW));
        return o;
    endfunction

    task automatic chk(input string nm, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, a, e);
        end
    endtask

    task automatic step(input obs_t e);
        expq.push_back(e);
        exp_log.push_back(e.st);
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit dec);
        start_i      = 1'($urandom_range(0, 1));
        halt_i       = 1'($urandom_range(0, 1));
        ifu_rvalid_i = 1'($urandom_range(0, 1));
        lsu_ack_i    = 1'($urandom_range(0, 1));
        if (dec) begin
            reg_wen_i      = 1'($urandom_range(0, 1));
            mem_wen_i      = 1'($urandom_range(0, 1));
            mem_ren_i      = 1'($urandom_range(0, 1));
            pc_sel_i       = 1'($urandom_range(0, 1));
            inst_illegal_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_ifu_req", ifu_req_o, 0);
        chk("rst_lsu_req", lsu_req_o, 0);
        chk("rst_trap", trap_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pc_src", pc_src_o, 0);
        chk("rst_inst_cnt", inst_cnt_o, 0);
        model_cnt    = 0;
        model_pc_src = 1'b0;
        start_i      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            noise(1);
            start_i = 1'b0;
            step(mk(3'd0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic idle_start();
        noise(1);
        start_i = 1'b1;
        step(mk(3'd0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic trap_hold(input int n);
        for (int k = 0; k < n; k++) begin
            noise(1);
            start_i = (k % 2 == 0);
            step(mk(3'd6, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // One instruction starting in a fetch cycle. outcome: 0 retired, 1 trapped, 2 reset mid-MEM.
    task automatic run_instr(input int f_lat, input bit ill, input bit wen, input bit ren,
                             input bit rw, input bit ps, input int m_lat, input bit halt,
                             input int rst_at, output int outcome);
        bit got;
        got = 0;
        for (int i = 0; i < TMO; i++) begin
            noise(1);
            ifu_rvalid_i = (i == f_lat);
            step(mk(3'd1, (i == f_lat), 1'b0, 1'b0));
            if (i == f_lat) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            outcome = 1;
            return;
        end
        noise(0);
        inst_illegal_i = ill;
        mem_wen_i      = wen;
        mem_ren_i      = ren;
        reg_wen_i      = rw;
        pc_sel_i       = ps;
        step(mk(3'd2, 1'b0, 1'b0, 1'b0));
        if (ill || (wen && ren)) begin
            outcome = 1;
            return;
        end
        model_pc_src = ps;
        noise(0);
        step(mk(3'd3, 1'b0, 1'b0, 1'b0));
        if (wen || ren) begin
            got = 0;
            for (int i = 0; i < TMO; i++) begin
                noise(0);
                lsu_ack_i = (i == m_lat);
                if (i == rst_at) begin
                    do_reset();
                    outcome = 2;
                    return;
                end
                step(mk(3'd4, 1'b0, wen, 1'b0));
                if (i == m_lat) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                outcome = 1;
                return;
            end
        end
        noise(0);
        halt_i = halt;
        step(mk(3'd5, 1'b0, 1'b0, rw));
        model_cnt++;
        outcome = 0;
    endtask

    task automatic clear_stats();
        st_log.delete();
        exp_log.delete();
        rf_cnt = 0; pc_cnt = 0; lsu_hi = 0; lsu_we_hi = 0; mem_cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] alu_seq [8];
        int  oc;
        bit  need_start;
        bit  wen, ren;
        int  op, f, m, r;
        alu_seq = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};

        #2;
        do_reset();

        // ALU instruction, instruction arrives on the third fetch cycle
        clear_stats();
        idle_start();
        run_instr(2, 0, 0, 0, 1, 1, 0, 0, -1, oc);
        noise(1);
        ifu_rvalid_i = 1'b0;
        step(mk(3'd1, 1'b0, 1'b0, 1'b0));
        chk("alu_seq_len", st_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < st_log.size()) chk("alu_seq_dut", st_log[i], alu_seq[i]);
            chk("alu_seq_model", exp_log[i], alu_seq[i]);
        end
        chk("alu_rf_we_pulses", rf_cnt, 1);
        chk("alu_pc_we_pulses", pc_cnt, 1);
        chk("alu_inst_cnt", inst_cnt_o, 1);
        chk("alu_pc_src", pc_src_o, 1);
        do_reset();

        // store with ack on the third MEM cycle, then halt
        clear_stats();
        idle_start();
        run_instr(0, 0, 1, 0, 0, 0, 2, 1, -1, oc);
        idle(2);
        chk("store_lsu_req_cycles", lsu_hi, 3);
        chk("store_lsu_we_cycles", lsu_we_hi, 3);
        chk("store_rf_we_pulses", rf_cnt, 0);
        chk("store_state_idle", state_o, 0);

        // illegal instruction: trap is sticky and start is ignored
        idle_start();
        run_instr(0, 1, 0, 0, 1, 0, 0, 0, -1, oc);
        trap_hold(5);
        chk("illegal_trap", trap_o, 1);
        do_reset();

        // load never acknowledged: trap after exactly TMO MEM cycles
        clear_stats();
        idle_start();
        run_instr(1, 0, 0, 1, 1, 0, 99, 1, -1, oc);
        trap_hold(3);
        chk("timeout_mem_cycles", mem_cyc, 4);
        do_reset();

        // ack on the last allowed MEM cycle wins over the timeout
        clear_stats();
        idle_start();
        run_instr(0, 0, 0, 1, 1, 0, TMO - 1, 1, -1, oc);
        idle(1);
        chk("late_ack_mem_cycles", mem_cyc, 4);
        chk("late_ack_inst_cnt", inst_cnt_o, 1);

        // fetch timeout
        idle_start();
        run_instr(TMO + 3, 0, 0, 0, 1, 0, 0, 0, -1, oc);
        trap_hold(2);
        do_reset();

        // reset asserted while a load is in flight
        idle_start();
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, -1, oc);
        run_instr(1, 0, 0, 1, 1, 0, 3, 0, 1, oc);
        idle(2);

        // sixteen retires wrap the 4-bit counter back to zero
        idle_start();
        for (int k = 0; k < 16; k++) begin
            run_instr(k % 3, 0, (k % 4 == 1), (k % 4 == 2), 1, k[0], k % 2, (k == 15), -1, oc);
        end
        idle(1);
        chk("wrap_inst_cnt", inst_cnt_o, 0);
        chk("wrap_state_idle", state_o, 0);

        // randomized instruction stream
        need_start = 1;
        for (int n = 0; n < 300; n++) begin
            if (need_start) begin
                idle($urandom_range(0, 2));
                idle_start();
            end
            f   = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
            op  = $urandom_range(0, 2);
            wen = (op == 2);
            ren = (op == 1);
            if ($urandom_range(0, 19) == 0) begin
                wen = 1;
                ren = 1;
            end
            m = ($urandom_range(0, 9) == 0) ? TMO + 2 : $urandom_range(0, TMO - 1);
            r = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 1) : -1;
            run_instr(f, ($urandom_range(0, 19) == 0), wen, ren, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), m, ($urandom_range(0, 3) == 0), r, oc);
            if (oc == 1) begin
                trap_hold($urandom_range(1, 3));
                do_reset();
                need_start = 1;
            end else if (oc == 2) begin
                need_start = 1;
            end else begin
                need_start = (state_o == 3'd0) || (exp_log[exp_log.size() - 1] == 3'd5 && halt_i);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
